// File: rtl/fft_input_buffer.sv
// fft_input_buffer: frame buffer collecting DEPTH samples, then handing them to an FFT core.
//   Parameters: DEPTH (samples per frame, power of two), ADDR_W (log2 DEPTH), DATA_W (sample width).
//   Ports: clk; n_rst (synchronous, active-high reset); wr_en/wAddress/fft_init_data (sample writes);
//     rd_en/rd_addr/rd_data (registered reads, read-before-write); fft_done (core completion);
//     fft_start (one-cycle frame-ready pulse); busy (START or RUN); fill_count (distinct indices
//     written this frame); overrun (sticky, writes rejected while busy).
//   Macro FFT_INPUT_BUFFER_BITREV_EN: store writes at the bit-reversed wAddress (DIT input order).
module fft_input_buffer #(
  parameter int DEPTH = 512,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wAddress,
  input  logic [DATA_W-1:0] fft_init_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              fft_done,
  output logic              fft_start,
  output logic              busy,
  output logic [ADDR_W:0]   fill_count,
  output logic              overrun
);
  typedef enum logic [1:0] {FILL, START, RUN} state_t;
  localparam logic [ADDR_W:0] full = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] last = (ADDR_W+1)'(DEPTH - 1);
  state_t state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [ADDR_W-1:0] widx;
  logic accept, fresh;
`ifdef FFT_INPUT_BUFFER_BITREV_EN
  for (genvar i = 0; i < ADDR_W; i++) begin : g_rev
    assign widx[i] = wAddress[ADDR_W-1-i];
  end
`else
  assign widx = wAddress;
`endif
  // writes land in memory only while filling and not in reset, so reset leaves contents intact
  assign accept = state == FILL && wr_en && !n_rst;
  assign fresh = accept && !valid[widx];
  assign fft_start = state == START;
  assign busy = state != FILL;
  always_comb begin
    state_nxt = state == FILL  ? (fresh && fill_count == last ? START : FILL) :
                state == START ? RUN :
                fft_done       ? FILL : RUN;
  end
  always_ff @(posedge clk) begin
    if (n_rst) state <= FILL;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (n_rst) begin
      valid <= '0;
      fill_count <= '0;
      overrun <= 1'b0;
      rd_data <= '0;
    end else begin
      if (rd_en) rd_data <= mem[rd_addr];
      if (state == RUN && fft_done) begin
        valid <= '0;
        fill_count <= '0;
      end else if (fresh) begin
        valid[widx] <= 1'b1;
        if (fill_count != full) fill_count <= fill_count + 1'b1;
      end
      if (wr_en && state != FILL) overrun <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) mem[widx] <= fft_init_data;
  end
endmodule

// File: tb/tb_fft_input_buffer.sv
// tb_fft_input_buffer: randomized bench against a frame-level reference model of fft_input_buffer.
module tb_fft_input_buffer;
  localparam int DEPTH = 512, AW = 9, DW = 32;
  localparam int P_FILL = 0, P_START = 1, P_RUN = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic n_rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0, fft_done = 1'b0;
  logic [AW-1:0] wAddress = '0, rd_addr = '0;
  logic [DW-1:0] fft_init_data = '0;
  logic [DW-1:0] rd_data;
  logic fft_start, busy, overrun;
  logic [AW:0] fill_count;
  int vectors = 0, errors = 0;
  int phase = P_FILL;
  bit vset [int];
  logic [DW-1:0] mmem [int];
  bit ovr = 1'b0;
  logic [DW-1:0] erd = '0;
  bit erd_ok = 1'b0;

  fft_input_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .n_rst(n_rst), .wr_en(wr_en), .wAddress(wAddress), .fft_init_data(fft_init_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .fft_done(fft_done),
    .fft_start(fft_start), .busy(busy), .fill_count(fill_count), .overrun(overrun)
  );

  function automatic int sidx(input int a);
`ifdef FFT_INPUT_BUFFER_BITREV_EN
    int r = 0;
    for (int i = 0; i < AW; i++) if (a[i]) r |= 1 << (AW - 1 - i);
    return r;
`else
    return a;
`endif
  endfunction

  task automatic cyc(input bit w, input int wa, input logic [DW-1:0] wd, input bit r, input int ra,
                     input bit d, input bit rs);
    wr_en = w; wAddress = AW'(wa); fft_init_data = wd;
    rd_en = r; rd_addr = AW'(ra); fft_done = d; n_rst = rs;
    @(posedge clk);
    if (rs) begin
      phase = P_FILL; vset.delete(); ovr = 0; erd = '0; erd_ok = 1;
    end else begin
      if (r) begin
        erd_ok = mmem.exists(ra);
        erd = erd_ok ? mmem[ra] : '0;
      end
      if (w && phase == P_FILL) begin
        mmem[sidx(wa)] = wd;
        vset[sidx(wa)] = 1;
      end else if (w) ovr = 1;
      if (phase == P_FILL && vset.num() == DEPTH) phase = P_START;
      else if (phase == P_START) phase = P_RUN;
      else if (phase == P_RUN && d) begin
        phase = P_FILL;
        vset.delete();
      end
    end
    @(negedge clk);
    wr_en = 0; rd_en = 0; fft_done = 0; n_rst = 0;
  endtask

  task automatic test_reset();
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    vectors++; if (fft_start !== 1'b0) begin errors++; $display("FAIL reset_fft_start got %b want 0", fft_start); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (fill_count !== '0) begin errors++; $display("FAIL reset_fill_count got %0d want 0", fill_count); end
    vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    vectors++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
  endtask

  task automatic test_full_frame();
    int k;
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, i, DW'(i), 1'($urandom), $urandom_range(DEPTH - 1), 0, 0);
      vectors++; if (fill_count !== (AW+1)'(vset.num())) begin errors++; $display("FAIL frame_fill_count got %0d want %0d", fill_count, vset.num()); end
      vectors++; if (fft_start !== (phase == P_START)) begin errors++; $display("FAIL frame_fft_start at %0d got %b want %b", i, fft_start, phase == P_START); end
      if (erd_ok) begin vectors++; if (rd_data !== erd) begin errors++; $display("FAIL frame_rd_data got %h want %h", rd_data, erd); end end
    end
    vectors++; if (fft_start !== 1'b1) begin errors++; $display("FAIL frame_start_pulse got %b want 1", fft_start); end
    cyc(0, 0, 0, 0, 0, 0, 0);
    vectors++; if (fft_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL frame_run got start=%b busy=%b want 0/1", fft_start, busy); end
    repeat (32) begin
      k = $urandom_range(DEPTH - 1);
      cyc(0, 0, 0, 1, k, 0, 0);
      vectors++; if (rd_data !== erd) begin errors++; $display("FAIL frame_read idx %0d got %h want %h", k, rd_data, erd); end
    end
    k = $urandom_range(DEPTH - 1);
    cyc(1, k, 32'hDEAD_BEEF, 0, 0, 0, 0);
    vectors++; if (overrun !== ovr) begin errors++; $display("FAIL run_write_overrun got %b want %b", overrun, ovr); end
    cyc(0, 0, 0, 1, sidx(k), 0, 0);
    vectors++; if (rd_data !== erd) begin errors++; $display("FAIL run_write_unchanged got %h want %h", rd_data, erd); end
    cyc(0, 0, 0, 0, 0, 1, 0);
    vectors++; if (busy !== 1'b0 || fill_count !== '0 || overrun !== 1'b1) begin errors++; $display("FAIL done_return got busy=%b fill=%0d ovr=%b want 0/0/1", busy, fill_count, overrun); end
  endtask

  task automatic test_overwrite();
    int q[$];
    cyc(1, 5, 32'hA, 0, 0, 0, 0);
    cyc(1, 5, 32'hB, 0, 0, 0, 0);
    vectors++; if (fill_count !== 10'd1) begin errors++; $display("FAIL overwrite_count got %0d want 1", fill_count); end
    for (int i = 0; i < DEPTH; i++) if (i != 5) q.push_back(i);
    q.shuffle();
    foreach (q[j]) begin
      cyc(1, q[j], $urandom, 1'($urandom), $urandom_range(DEPTH - 1), 0, 0);
      vectors++; if (fill_count !== (AW+1)'(vset.num())) begin errors++; $display("FAIL overwrite_fill got %0d want %0d", fill_count, vset.num()); end
      if (erd_ok) begin vectors++; if (rd_data !== erd) begin errors++; $display("FAIL overwrite_rd got %h want %h", rd_data, erd); end end
    end
    cyc(0, 0, 0, 1, sidx(5), 0, 0);
    vectors++; if (rd_data !== 32'hB) begin errors++; $display("FAIL overwrite_read5 got %h want 0000000b", rd_data); end
    cyc(0, 0, 0, 0, 0, 1, 0);
    vectors++; if (busy !== (phase != P_FILL)) begin errors++; $display("FAIL overwrite_done got busy=%b want %b", busy, phase != P_FILL); end
  endtask

  task automatic test_done_in_fill_and_reset_midrun();
    int q[$];
    int starts = 0;
    for (int i = 0; i < DEPTH; i++) q.push_back(i);
    q.shuffle();
    for (int j = 0; j < 100; j++) cyc(1, q[j], $urandom, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    vectors++; if (fill_count !== 10'd100 || busy !== 1'b0) begin errors++; $display("FAIL done_in_fill got fill=%0d busy=%b want 100/0", fill_count, busy); end
    for (int j = 100; j < DEPTH; j++) cyc(1, q[j], $urandom, 0, 0, 0, 0);
    vectors++; if (fft_start !== 1'b1) begin errors++; $display("FAIL second_frame_start got %b want 1", fft_start); end
    cyc(0, 0, 0, 0, 0, 1, 0);
    vectors++; if (busy !== 1'b1 || fft_start !== 1'b0) begin errors++; $display("FAIL done_in_start got busy=%b start=%b want 1/0", busy, fft_start); end
    for (int j = 0; j < 300; j++) cyc(1, $urandom_range(DEPTH - 1), $urandom, 0, 0, 0, 0);
    vectors++; if (overrun !== 1'b1) begin errors++; $display("FAIL pending_overrun got %b want 1", overrun); end
    cyc(0, 0, 0, 1, 3, 0, 1);
    vectors++; if (busy !== 1'b0 || fft_start !== 1'b0 || fill_count !== '0 || overrun !== 1'b0 || rd_data !== '0) begin
      errors++; $display("FAIL midrun_reset got busy=%b start=%b fill=%0d ovr=%b rd=%h want all 0", busy, fft_start, fill_count, overrun, rd_data);
    end
    q.shuffle();
    foreach (q[j]) begin
      cyc(1, q[j], $urandom, 0, 0, 0, 0);
      if (fft_start) starts++;
      vectors++; if (fill_count !== (AW+1)'(vset.num())) begin errors++; $display("FAIL refill_count got %0d want %0d", fill_count, vset.num()); end
    end
    repeat (3) begin cyc(0, 0, 0, 0, 0, 0, 0); if (fft_start) starts++; end
    vectors++; if (starts != 1) begin errors++; $display("FAIL refill_start_pulses got %0d want 1", starts); end
  endtask

  task automatic test_back_to_back();
    int k = $urandom_range(DEPTH - 1);
    cyc(1, k, 32'h5555_AAAA, 0, 0, 1, 0);
    vectors++; if (overrun !== 1'b1 || busy !== 1'b0 || fill_count !== '0) begin errors++; $display("FAIL write_on_done got ovr=%b busy=%b fill=%0d want 1/0/0", overrun, busy, fill_count); end
    cyc(1, k, 32'hC0DE_0001, 1, sidx(k), 0, 0);
    vectors++; if (rd_data !== erd) begin errors++; $display("FAIL rbw_old got %h want %h", rd_data, erd); end
    cyc(0, 0, 0, 1, sidx(k), 0, 0);
    vectors++; if (rd_data !== 32'hC0DE_0001) begin errors++; $display("FAIL rbw_new got %h want c0de0001", rd_data); end
  endtask

  task automatic test_bitrev();
    int ra;
`ifdef FFT_INPUT_BUFFER_BITREV_EN
    ra = 256;
`else
    ra = 1;
`endif
    cyc(1, 1, 32'h1234, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, ra, 0, 0);
    vectors++; if (rd_data !== 32'h1234) begin errors++; $display("FAIL storage_order idx %0d got %h want 00001234", ra, rd_data); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_overwrite();
    test_done_in_fill_and_reset_midrun();
    test_back_to_back();
    test_bitrev();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/fft_input_buffer.md
FFT_INPUT_BUFFER -- requirements
Module: fft_input_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 512, sample count per FFT frame (power of two).
REQ-002 SHALL have parameter ADDR_W, default 9, equal to log2(DEPTH).
REQ-003 SHALL have parameter DATA_W, default 32, sample width (packed re/im as delivered by the Avalon slave).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port n_rst, input, 1, synchronous active-high reset (1 = reset, sampled on clk).
REQ-006 SHALL have port wr_en, input, 1, sample write strobe from the Avalon slave.
REQ-007 SHALL have port wAddress, input, ADDR_W, sample index for the write.
REQ-008 SHALL have port fft_init_data, input, DATA_W, sample value for the write.
REQ-009 SHALL have port rd_en, input, 1, FFT-core read request.
REQ-010 SHALL have port rd_addr, input, ADDR_W, FFT-core read index.
REQ-011 SHALL have port rd_data, output, DATA_W, read data.
REQ-012 SHALL have port fft_done, input, 1, FFT core completion pulse.
REQ-013 SHALL have port fft_start, output, 1, single-cycle frame-ready pulse to the FFT core.
REQ-014 SHALL have port busy, output, 1, high in START and RUN.
REQ-015 SHALL have port fill_count, output, ADDR_W+1, number of distinct indices written this frame.
REQ-016 SHALL have port overrun, output, 1, sticky flag for writes rejected while busy.

Function
REQ-017 SHALL hold a DEPTH x DATA_W sample memory plus a DEPTH-bit valid bitmap.
REQ-018 SHALL implement states FILL, START, RUN; reset state FILL.
REQ-019 In FILL, wr_en SHALL write fft_init_data to the storage index and set its valid bit at the next edge.
REQ-020 In FILL, a write to an invalid index SHALL increment fill_count; a write to an already-valid index SHALL overwrite data without incrementing.
REQ-021 FILL->START SHALL occur on the edge where fill_count reaches DEPTH; fft_start SHALL be 1 for exactly the START cycle.
REQ-022 START->RUN SHALL occur unconditionally after one cycle.
REQ-023 RUN->FILL SHALL occur on the edge fft_done is sampled 1; the same edge SHALL clear all valid bits and fill_count to 0.
REQ-024 fft_done in FILL or START SHALL be ignored.
REQ-025 wr_en in START or RUN SHALL not modify memory or bitmap and SHALL set overrun.
REQ-026 rd_en SHALL be honoured in every state; rd_data SHALL present mem[rd_addr] one cycle after rd_en and hold otherwise.
REQ-027 A write and a read to the same index in one cycle SHALL return the old data (read-before-write).
REQ-028 A write in the cycle fft_done returns the block to FILL SHALL be rejected (state is RUN that cycle) and set overrun.
REQ-029 fill_count SHALL saturate at DEPTH and never wrap.

Reset
REQ-030 n_rst=1 SHALL force state FILL, fft_start=0, busy=0, fill_count=0, overrun=0, rd_data=0, all valid bits 0, effective the next edge, including mid-RUN.
REQ-031 Reset SHALL not clear sample memory contents; they are undefined until rewritten.
REQ-032 overrun SHALL clear only on reset.

Configuration
REQ-033 With macro FFT_INPUT_BUFFER_BITREV_EN defined, storage index SHALL be wAddress bit-reversed over ADDR_W bits (DIT input ordering); rd_addr is used unmodified.
REQ-034 Without FFT_INPUT_BUFFER_BITREV_EN, storage index SHALL equal wAddress (natural order).

Verification
REQ-035 Write indices 0..511 with data=index, no macro -> fft_start pulses one cycle after write 511's edge; reads of index k return k one cycle later.
REQ-036 Write index 5 twice (0xA then 0xB) -> fill_count=1; after full frame, read 5 returns 0xB.
REQ-037 With FFT_INPUT_BUFFER_BITREV_EN, write index 1 data 0x1234 -> read of index 256 returns 0x1234.
REQ-038 Full frame, write during RUN -> overrun=1, target data unchanged; fft_done pulse -> FILL, fill_count=0, busy=0, overrun stays 1.
REQ-039 Assert n_rst during RUN after 300 writes of next frame pending -> all outputs reset values; next 512 writes produce one fft_start.
REQ-040 fft_done pulsed in FILL with fill_count=100 -> no state change, fill_count stays 100.
